// File: rtl/ccu_sequencer.sv
// ccu_sequencer: single-issue command sequencer in front of an external ALU.
// Holds a 4 x 8-bit register file. Each accepted command latches its operands,
// presents them to the ALU for two cycles, captures the ALU response, and
// commits it in a final writeback cycle. Throughput is one command every four cycles.
//
// state        | meaning
// -------------+-------------------------------------------------------------
// ST_IDLE      | ready for a command; cmd_ready high, ALU operands held at 0
// ST_ISSUE     | latched operands/opcode presented to the ALU
// ST_CAPTURE   | operands still presented; ALU result/cc/we registered at exit
// ST_WRITEBACK | commit (or reject) the captured result; done/err pulse

module ccu_sequencer (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic [3:0]  cmd_op,
   input  logic [1:0]  cmd_ra,
   input  logic [1:0]  cmd_rb,
   input  logic [1:0]  cmd_rd,
   input  logic        cmd_use_imm,
   input  logic [7:0]  cmd_imm,
   output logic [7:0]  alu_a,
   output logic [7:0]  alu_b,
   output logic [3:0]  alu_n,
   input  logic [7:0]  alu_r,
   input  logic [3:0]  alu_cc,
   input  logic        alu_we,
   output logic        done,
   output logic        err,
   output logic [3:0]  flags,
   input  logic [1:0]  rd_sel,
   output logic [7:0]  rd_data,
   output logic [15:0] op_count
);

   typedef enum logic [1:0] {
      ST_IDLE      = 2'd0,
      ST_ISSUE     = 2'd1,
      ST_CAPTURE   = 2'd2,
      ST_WRITEBACK = 2'd3
   } state_t;

   state_t      state_q, state_d;

   logic [7:0]  regs_q [4];
   logic [7:0]  regs_d [4];
   logic [3:0]  flags_q, flags_d;
   logic [15:0] cnt_q, cnt_d;

   // Command latched at acceptance; operands are snapshots so rd==ra/rb is safe.
   logic [3:0]  op_q, op_d;
   logic [1:0]  rd_q, rd_d;
   logic [7:0]  a_q, a_d;
   logic [7:0]  b_q, b_d;

   // ALU response captured at the end of ST_CAPTURE.
   logic [7:0]  r_q, r_d;
   logic [3:0]  cc_q, cc_d;
   logic        we_q, we_d;

   logic        wb_valid;

   // Opcodes 8-15 are undefined; the ALU write enable can also veto a commit.
   assign wb_valid = (op_q[3] == 1'b0) && we_q;

   // Next-state, datapath updates and per-state outputs.
   always_comb begin
      state_d   = state_q;
      regs_d    = regs_q;
      flags_d   = flags_q;
      cnt_d     = cnt_q;
      op_d      = op_q;
      rd_d      = rd_q;
      a_d       = a_q;
      b_d       = b_q;
      r_d       = r_q;
      cc_d      = cc_q;
      we_d      = we_q;
      cmd_ready = 1'b0;
      alu_a     = 8'h00;
      alu_b     = 8'h00;
      alu_n     = 4'h0;
      done      = 1'b0;
      err       = 1'b0;

      case (state_q)
         ST_IDLE: begin
            cmd_ready = 1'b1;
            if (cmd_valid) begin
               op_d    = cmd_op;
               rd_d    = cmd_rd;
               a_d     = regs_q[cmd_ra];
               b_d     = cmd_use_imm ? cmd_imm : regs_q[cmd_rb];
               state_d = ST_ISSUE;
            end
         end
         ST_ISSUE: begin
            alu_a   = a_q;
            alu_b   = b_q;
            alu_n   = op_q;
            state_d = ST_CAPTURE;
         end
         ST_CAPTURE: begin
            alu_a   = a_q;
            alu_b   = b_q;
            alu_n   = op_q;
            r_d     = alu_r;
            cc_d    = alu_cc;
            we_d    = alu_we;
            state_d = ST_WRITEBACK;
         end
         ST_WRITEBACK: begin
            done = 1'b1;
            if (wb_valid) begin
               regs_d[rd_q] = r_q;
               flags_d      = cc_q;
               cnt_d        = cnt_q + 16'd1;
            end else begin
               err = 1'b1;
            end
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State and datapath registers; reset aborts any in-flight command.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= ST_IDLE;
         for (int i = 0; i < 4; i++) begin
            regs_q[i] <= 8'h00;
         end
         flags_q <= 4'h0;
         cnt_q   <= 16'h0000;
         op_q    <= 4'h0;
         rd_q    <= 2'd0;
         a_q     <= 8'h00;
         b_q     <= 8'h00;
         r_q     <= 8'h00;
         cc_q    <= 4'h0;
         we_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         for (int i = 0; i < 4; i++) begin
            regs_q[i] <= regs_d[i];
         end
         flags_q <= flags_d;
         cnt_q   <= cnt_d;
         op_q    <= op_d;
         rd_q    <= rd_d;
         a_q     <= a_d;
         b_q     <= b_d;
         r_q     <= r_d;
         cc_q    <= cc_d;
         we_q    <= we_d;
      end
   end

   assign flags    = flags_q;
   assign op_count = cnt_q;
   assign rd_data  = regs_q[rd_sel];

endmodule

// File: tb/tb_ccu_sequencer.sv
// Directed bench for ccu_sequencer with a behavioural ALU as the responder.
// ALU cc layout: {a_lt_b, a_eq_b, zero, carry}; max/min set only the compare
// bits, arithmetic/shift/pass set zero and carry. The ALU asserts we unless
// the bench forces it low, so undefined opcodes are rejected by the sequencer.

module tb_ccu_sequencer;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        cmd_valid;
   logic        cmd_ready;
   logic [3:0]  cmd_op;
   logic [1:0]  cmd_ra, cmd_rb, cmd_rd;
   logic        cmd_use_imm;
   logic [7:0]  cmd_imm;
   logic [7:0]  alu_a, alu_b;
   logic [3:0]  alu_n;
   logic [7:0]  alu_r;
   logic [3:0]  alu_cc;
   logic        alu_we;
   logic        done, err;
   logic [3:0]  flags;
   logic [1:0]  rd_sel;
   logic [7:0]  rd_data;
   logic [15:0] op_count;

   logic        force_we0;

   int          n_tests = 0;
   int          n_fail  = 0;

   logic [7:0]  mreg [4];
   logic [3:0]  mflags;
   logic [15:0] mcount;

   always #5 clk = ~clk;

   ccu_sequencer dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .cmd_valid   (cmd_valid),
      .cmd_ready   (cmd_ready),
      .cmd_op      (cmd_op),
      .cmd_ra      (cmd_ra),
      .cmd_rb      (cmd_rb),
      .cmd_rd      (cmd_rd),
      .cmd_use_imm (cmd_use_imm),
      .cmd_imm     (cmd_imm),
      .alu_a       (alu_a),
      .alu_b       (alu_b),
      .alu_n       (alu_n),
      .alu_r       (alu_r),
      .alu_cc      (alu_cc),
      .alu_we      (alu_we),
      .done        (done),
      .err         (err),
      .flags       (flags),
      .rd_sel      (rd_sel),
      .rd_data     (rd_data),
      .op_count    (op_count)
   );

   // Behavioural ALU responder.
   always_comb begin
      logic [8:0] wide;
      wide   = 9'h000;
      alu_r  = 8'h00;
      alu_cc = 4'h0;
      alu_we = !force_we0;
      case (alu_n)
         4'd0: begin
            wide   = {1'b0, alu_a} + {1'b0, alu_b};
            alu_r  = wide[7:0];
            alu_cc = {2'b00, wide[7:0] == 8'h00, wide[8]};
         end
         4'd1: begin
            wide   = {1'b0, alu_a} - {1'b0, alu_b};
            alu_r  = wide[7:0];
            alu_cc = {2'b00, wide[7:0] == 8'h00, wide[8]};
         end
         4'd2: begin
            alu_r  = {alu_a[6:0], 1'b0};
            alu_cc = {2'b00, alu_r == 8'h00, alu_a[7]};
         end
         4'd3: begin
            alu_r  = {1'b0, alu_a[7:1]};
            alu_cc = {2'b00, alu_r == 8'h00, alu_a[0]};
         end
         4'd4: begin
            alu_r  = alu_a;
            alu_cc = {2'b00, alu_r == 8'h00, 1'b0};
         end
         4'd5: begin
            alu_r  = alu_b;
            alu_cc = {2'b00, alu_r == 8'h00, 1'b0};
         end
         4'd6: begin
            alu_r  = (alu_a > alu_b) ? alu_a : alu_b;
            alu_cc = {alu_a < alu_b, alu_a == alu_b, 2'b00};
         end
         4'd7: begin
            alu_r  = (alu_a < alu_b) ? alu_a : alu_b;
            alu_cc = {alu_a < alu_b, alu_a == alu_b, 2'b00};
         end
         default: begin
            alu_r  = 8'hEE;
            alu_cc = 4'hF;
         end
      endcase
   end

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // One full command: accept, check ISSUE/CAPTURE/WRITEBACK/IDLE behaviour.
   task automatic do_cmd(input string tag, input logic [3:0] op, input logic [1:0] ra,
                         input logic [1:0] rb, input logic [1:0] rd, input logic use_imm,
                         input logic [7:0] imm, input logic [7:0] exp_r,
                         input logic [3:0] exp_cc, input logic exp_err);
      logic [7:0] exp_a, exp_b;
      int         n;
      exp_a = mreg[ra];
      exp_b = use_imm ? imm : mreg[rb];
      @(negedge clk);
      n = 0;
      while (!cmd_ready && n < 8) begin
         @(negedge clk);
         n++;
      end
      check_val({tag, "_ready"}, 32'(cmd_ready), 32'd1);
      cmd_op      = op;
      cmd_ra      = ra;
      cmd_rb      = rb;
      cmd_rd      = rd;
      cmd_use_imm = use_imm;
      cmd_imm     = imm;
      cmd_valid   = 1'b1;
      @(posedge clk);
      #1;
      cmd_valid = 1'b0;
      cmd_op    = 4'hF;
      cmd_imm   = 8'hAA;
      cmd_ra    = ~ra;
      @(negedge clk);
      check_val({tag, "_iss_rdy"}, 32'(cmd_ready), 32'd0);
      check_val({tag, "_iss_done"}, 32'(done), 32'd0);
      check_val({tag, "_alu_a"}, 32'(alu_a), 32'(exp_a));
      check_val({tag, "_alu_b"}, 32'(alu_b), 32'(exp_b));
      check_val({tag, "_alu_n"}, 32'(alu_n), 32'(op));
      @(negedge clk);
      check_val({tag, "_cap_done"}, 32'(done), 32'd0);
      check_val({tag, "_cap_alu_a"}, 32'(alu_a), 32'(exp_a));
      @(negedge clk);
      rd_sel = rd;
      #1;
      check_val({tag, "_wb_done"}, 32'(done), 32'd1);
      check_val({tag, "_wb_err"}, 32'(err), 32'(exp_err));
      check_val({tag, "_wb_old"}, 32'(rd_data), 32'(mreg[rd]));
      if (!exp_err) begin
         mreg[rd] = exp_r;
         mflags   = exp_cc;
         mcount   = mcount + 16'd1;
      end
      @(negedge clk);
      check_val({tag, "_idle_done"}, 32'(done), 32'd0);
      check_val({tag, "_idle_err"}, 32'(err), 32'd0);
      check_val({tag, "_idle_alu_a"}, 32'(alu_a), 32'd0);
      check_val({tag, "_result"}, 32'(rd_data), 32'(mreg[rd]));
      check_val({tag, "_flags"}, 32'(flags), 32'(mflags));
      check_val({tag, "_count"}, 32'(op_count), 32'(mcount));
   endtask

   initial begin
      #100000;
      $display("FAIL timeout: simulation did not finish within bound");
      $fatal(1, "timeout");
   end

   initial begin
      logic [11:0] rdy_hist;
      int          accepts;
      logic        seen_done;

      reset_n     = 1'b0;
      cmd_valid   = 1'b0;
      cmd_op      = 4'h0;
      cmd_ra      = 2'd0;
      cmd_rb      = 2'd0;
      cmd_rd      = 2'd0;
      cmd_use_imm = 1'b0;
      cmd_imm     = 8'h00;
      rd_sel      = 2'd0;
      force_we0   = 1'b0;
      for (int i = 0; i < 4; i++) mreg[i] = 8'h00;
      mflags = 4'h0;
      mcount = 16'h0000;

      // Reset state
      #3;
      check_val("rst_ready", 32'(cmd_ready), 32'd1);
      check_val("rst_done", 32'(done), 32'd0);
      check_val("rst_err", 32'(err), 32'd0);
      check_val("rst_flags", 32'(flags), 32'd0);
      check_val("rst_count", 32'(op_count), 32'd0);
      check_val("rst_alu", 32'({alu_a, alu_b, alu_n}), 32'd0);
      check_val("rst_reg0", 32'(rd_data), 32'd0);
      @(negedge clk);
      reset_n = 1'b1;

      // Add with carry-out to zero
      do_cmd("ld_r0", 4'd5, 2'd0, 2'd0, 2'd0, 1'b1, 8'h80, 8'h80, 4'b0000, 1'b0);
      do_cmd("ld_r1", 4'd5, 2'd0, 2'd0, 2'd1, 1'b1, 8'h80, 8'h80, 4'b0000, 1'b0);
      do_cmd("add",   4'd0, 2'd0, 2'd1, 2'd2, 1'b0, 8'h00, 8'h00, 4'b0011, 1'b0);

      // Subtract with borrow
      do_cmd("ld_r0b", 4'd5, 2'd0, 2'd0, 2'd0, 1'b1, 8'h05, 8'h05, 4'b0000, 1'b0);
      do_cmd("sub",    4'd1, 2'd0, 2'd0, 2'd1, 1'b1, 8'h07, 8'hFE, 4'b0001, 1'b0);

      // Max equal, min less-than
      do_cmd("ld_r0c", 4'd5, 2'd0, 2'd0, 2'd0, 1'b1, 8'h10, 8'h10, 4'b0000, 1'b0);
      do_cmd("max",    4'd6, 2'd0, 2'd0, 2'd3, 1'b1, 8'h10, 8'h10, 4'b0100, 1'b0);
      do_cmd("ld_r0d", 4'd5, 2'd0, 2'd0, 2'd0, 1'b1, 8'h03, 8'h03, 4'b0000, 1'b0);
      do_cmd("min",    4'd7, 2'd0, 2'd0, 2'd3, 1'b1, 8'h09, 8'h03, 4'b1000, 1'b0);

      // Destination equals both sources: operands are pre-write values
      do_cmd("self",   4'd0, 2'd0, 2'd0, 2'd0, 1'b0, 8'h00, 8'h06, 4'b0000, 1'b0);
      // Shifts: r1 = 0xFE doubled, r3 = 0x03 halved
      do_cmd("dbl",    4'd2, 2'd1, 2'd0, 2'd2, 1'b0, 8'h00, 8'hFC, 4'b0001, 1'b0);
      do_cmd("half",   4'd3, 2'd3, 2'd0, 2'd1, 1'b0, 8'h00, 8'h01, 4'b0001, 1'b0);
      do_cmd("passa",  4'd4, 2'd2, 2'd0, 2'd3, 1'b0, 8'h00, 8'hFC, 4'b0000, 1'b0);

      // Undefined opcode and ALU write-enable veto
      do_cmd("badop",  4'd9, 2'd0, 2'd1, 2'd0, 1'b0, 8'h00, 8'h00, 4'b0000, 1'b1);
      force_we0 = 1'b1;
      do_cmd("we0",    4'd0, 2'd0, 2'd1, 2'd1, 1'b1, 8'h01, 8'h00, 4'b0000, 1'b1);
      force_we0 = 1'b0;

      // cmd_valid held for 12 cycles: accepts on cycles 0, 4 and 8 only
      @(negedge clk);
      cmd_op      = 4'd5;
      cmd_rd      = 2'd1;
      cmd_use_imm = 1'b1;
      cmd_imm     = 8'h42;
      cmd_valid   = 1'b1;
      rdy_hist    = '0;
      for (int i = 0; i < 12; i++) begin
         rdy_hist = {rdy_hist[10:0], cmd_ready};
         @(negedge clk);
      end
      cmd_valid = 1'b0;
      accepts = 0;
      for (int i = 0; i < 12; i++) accepts += int'(rdy_hist[i]);
      check_val("hold_pattern", 32'(rdy_hist), 32'h888);
      check_val("hold_accepts", 32'(accepts), 32'd3);
      mreg[1] = 8'h42;
      mflags  = 4'b0000;
      mcount  = mcount + 16'd3;
      rd_sel  = 2'd1;
      #1;
      check_val("hold_reg1", 32'(rd_data), 32'h42);
      check_val("hold_count", 32'(op_count), 32'(mcount));

      // Reset during CAPTURE of a write to reg3
      @(negedge clk);
      cmd_op      = 4'd5;
      cmd_rd      = 2'd3;
      cmd_use_imm = 1'b1;
      cmd_imm     = 8'h55;
      cmd_valid   = 1'b1;
      @(posedge clk);
      #1;
      cmd_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      check_val("abort_in_cap", 32'(alu_n), 32'd5);
      reset_n = 1'b0;
      rd_sel  = 2'd3;
      #1;
      check_val("abort_ready", 32'(cmd_ready), 32'd1);
      check_val("abort_alu", 32'({alu_a, alu_b, alu_n}), 32'd0);
      check_val("abort_count", 32'(op_count), 32'd0);
      check_val("abort_flags", 32'(flags), 32'd0);
      seen_done = 1'b0;
      for (int i = 0; i < 4; i++) begin
         #2;
         seen_done = seen_done | done;
      end
      @(negedge clk);
      seen_done = seen_done | done;
      check_val("abort_no_done", 32'(seen_done), 32'd0);
      check_val("abort_reg3", 32'(rd_data), 32'd0);
      for (int i = 0; i < 4; i++) mreg[i] = 8'h00;
      mflags = 4'h0;
      mcount = 16'h0000;

      // Release with a command waiting: accepted on the first edge
      reset_n   = 1'b1;
      cmd_valid = 1'b1;
      @(posedge clk);
      #1;
      cmd_valid = 1'b0;
      check_val("first_edge_acc", 32'(cmd_ready), 32'd0);
      @(negedge clk);
      @(negedge clk);
      @(negedge clk);
      check_val("post_rst_done", 32'(done), 32'd1);
      @(negedge clk);
      check_val("post_rst_reg3", 32'(rd_data), 32'h55);
      check_val("post_rst_count", 32'(op_count), 32'd1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
